// File: rtl/i2c_arb.sv
// i2c_arb: round-robin arbiter sequencing N requesters onto one i2c master core
module i2c_arb #(
  parameter int N = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   req_wr,
  input  logic [3*N-1:0] req_addr,
  input  logic [8*N-1:0] req_wdata,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   err,
  output logic [7:0]     rdata,
  output logic           busy,
  output logic           core_en,
  output logic [2:0]     core_maddr,
  output logic [7:0]     core_wdata,
  output logic           core_wr,
  input  logic           core_done,
  input  logic [7:0]     core_rdata
);
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [N-1:0] gnt_q, gnt_d, ack_q, ack_d, err_q, err_d;
  logic [7:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [2:0] maddr_q, maddr_d;
  logic busy_q, busy_d, en_q, en_d, wr_q, wr_d;
  logic [IW-1:0] last_q, last_d;
  logic [TW-1:0] tmr_q, tmr_d;
  int win, idx;
  logic found;
  // round-robin search starting just after the last winner
  always_comb begin
    win = int'(last_q);
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!found && req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  // next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    en_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    last_d  = last_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = LAUNCH;
        gnt_d   = N'(1) << win;
        maddr_d = req_addr[3*win +: 3];
        wdata_d = req_wdata[8*win +: 8];
        wr_d    = req_wr[win];
        last_d  = IW'(win);
        en_d    = 1'b1;
      end
      LAUNCH: begin
        tmr_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tmr_d = tmr_q + 1'b1;
        if (core_done) begin
          ack_d   = gnt_q;
          rdata_d = wr_q ? rdata_q : core_rdata;
          state_d = DONE;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          err_d   = gnt_q;
          state_d = DONE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // state and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= 8'h00;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      maddr_q <= 3'b000;
      wdata_q <= 8'h00;
      wr_q    <= 1'b0;
      last_q  <= IW'(N - 1);
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      last_q  <= last_d;
      tmr_q   <= tmr_d;
    end
  end
  assign gnt        = gnt_q;
  assign ack        = ack_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign core_en    = en_q;
  assign core_maddr = maddr_q;
  assign core_wdata = wdata_q;
  assign core_wr    = wr_q;
endmodule

// File: doc/i2c_arb.md
# i2c_arb

Round-robin arbiter and sequencer that shares one `i2c` master core among `N` requesters. It accepts per-requester read/write requests, latches the winner's address, data and direction onto the core's inputs, and pulses the core enable. It then waits for the core to report completion, returns read data with a per-requester acknowledge, and aborts with an error if the core does not finish within a bounded time.

## Interface
- `N`, default 4: number of requesters, from 2 to 8.
- `TIMEOUT`, default 64: number of WAIT cycles before abort, at least 2. The timer width is clog2(TIMEOUT).
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: reset is synchronous and active-low (asserted when 0).
- `req` in N: per-requester request level. Hold it until `ack` or `err` for that requester.
- `req_wr` in N: per-requester direction, 1 = write, 0 = read.
- `req_addr` in 3N: per-requester 3-bit slave address; requester i uses bits [3i+2:3i].
- `req_wdata` in 8N: per-requester write byte; requester i uses bits [8i+7:8i].
- `gnt` out N: one-hot grant, held for the whole transaction.
- `ack` out N: one-cycle pulse when the transaction completes normally.
- `err` out N: one-cycle pulse when the transaction times out.
- `rdata` out 8: read byte, valid while `ack` is high on a read.
- `busy` out 1: high in every state except IDLE.
- `core_en` out 1: enable to the core, one-cycle pulse.
- `core_maddr` out 3: address to the core.
- `core_wdata` out 8: byte to the core.
- `core_wr` out 1: direction to the core.
- `core_done` in 1: one-cycle pulse from the core when it returns to idle.
- `core_rdata` in 8: read byte from the core, valid with `core_done`.

## Operation
- The state machine has four states: IDLE, LAUNCH, WAIT, DONE. All outputs are registered.
- IDLE
  - If `req` is nonzero, pick a winner by round-robin: search from index `last`+1 upward, wrapping modulo N.
  - Register `gnt` as one-hot for the winner.
  - Load `core_maddr`, `core_wdata` and `core_wr` from the winner's slice.
  - Set `last` to the winner, set `core_en` to 1, and go to LAUNCH.
  - If `req` is zero, stay in IDLE.
- LAUNCH
  - `core_en` is high for exactly this one cycle.
  - Clear the timer and go to WAIT.
  - A `core_done` sampled in LAUNCH is ignored.
- WAIT
  - `core_en` is 0 and the timer increments each cycle.
  - If `core_done` is 1: set the winner's `ack` bit. If `core_wr` is 0, capture `core_rdata` into `rdata`. Go to DONE.
  - Else, if timer == TIMEOUT-1: set the winner's `err` bit, leave `rdata` unchanged, and go to DONE.
  - If `core_done` arrives on the same cycle the timer reaches its limit, `core_done` wins: `ack` is raised, not `err`.
- DONE
  - `ack` or `err` is high for this one cycle.
  - Next cycle: clear `ack`, `err` and `gnt`, then go to IDLE.
- Requester behaviour
  - Changes to `req`, `req_wr`, `req_addr` or `req_wdata` after the grant are ignored, because the fields are latched in IDLE.
  - Dropping `req` mid-transaction does not abort; the transaction completes and `ack` or `err` is still issued.
  - A requester that keeps `req` high after `ack` is re-arbitrated in the following IDLE cycle, in normal round-robin order.
  - At most one requester's bit of `gnt`, `ack` and `err` is ever set.
- Reset (`rst`=0): state = IDLE, `last` = N-1 (so requester 0 has first priority), `gnt` = 0, `ack` = 0, `err` = 0, `rdata` = 8'h00, `busy` = 0, `core_en` = 0, `core_maddr` = 3'b000, `core_wdata` = 8'h00, `core_wr` = 0, timer = 0.
- Reset mid-transaction abandons it immediately, with no `ack` or `err`.

## Timing
- Request to core:
  - `req` sampled high at edge t (IDLE).
  - `gnt` and `core_*` are valid from t+1.
  - `core_en` is high during cycle t+1 only.
- WAIT begins at edge t+2.
- Completion:
  - `core_done` sampled at edge w gives `ack` (and `rdata`) high during cycle w+1 only.
  - `gnt` drops at w+2.
- Minimum request-to-`ack` latency: 3 cycles.
- Timeout: `err` is high during cycle t+2+TIMEOUT.
- Back-to-back throughput: one IDLE cycle between DONE and the next LAUNCH.
- `busy` = (state != IDLE), registered alongside the state.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with random inputs → every output matches its reset value and `busy`=0.
- Single write: `req`=4'b0010, requester 1 with `req_addr`=3'd5 and `req_wdata`=8'hA5, `req_wr`=1; `core_done` pulsed 10 cycles after `core_en` → `gnt`=4'b0010 from t+1; `core_maddr`=5, `core_wdata`=8'hA5 and `core_wr`=1; one `core_en` pulse; `ack`=4'b0010 for 1 cycle; `rdata` unchanged.
- Read: requester 3 reads; the core returns `core_rdata`=8'h3C with `core_done` → `rdata`=8'h3C while `ack`=4'b1000.
- Round-robin fairness: `req`=4'b1111 held, `core_done` returned promptly → grant order 0,1,2,3,0; no requester is granted twice before all others have been granted once.
- Timeout: no `core_done` → `err` pulses for the granted requester at t+2+TIMEOUT with no `ack`; the next request is served normally. Also pulse `core_done` on the exact limit cycle → `ack`, not `err`.
- Mid-transaction events:
  - A `core_done` pulse during LAUNCH is ignored.
  - `req` dropped during WAIT: `ack` is still issued.
  - `rst`=0 during WAIT: no `ack` is issued and all outputs return to reset values the next cycle.
